ring_modulator_core: RTL and testbench
======================================

// Module: ring_modulator_core
// PURPOSE
//  Audio-path stage fed by the ring-modulation controller. Takes its carrier step period
//  (frequency) and bypass flag (disabled) and generates a 32-step triangle carrier.
//  Multiplies each stereo sample pair from the codec input path by the carrier and hands
//  the result to the codec output path. One shared multiplier, sequenced L then R.
// PARAMETERS
//  DATA_W          16    signed audio sample width
//  DEFAULT_PERIOD  3551  carrier step period after reset, in CLK cycles (440 Hz at 50 MHz, 32 steps)
//  MIN_PERIOD      2     any frequency value below this is clamped up to it
// PORTS
//  CLK               in   1       system clock, all logic on posedge
//  RST_N             in   1       asynchronous active-low reset
//  frequency         in   32      carrier step period in CLK cycles, from controller
//  disabled          in   1       1 = bypass (no modulation), from controller
//  left_in           in   DATA_W  signed left sample
//  right_in          in   DATA_W  signed right sample
//  sample_in_valid   in   1       1-cycle strobe, left_in/right_in valid
//  left_out          out  DATA_W  signed processed left sample
//  right_out         out  DATA_W  signed processed right sample
//  sample_out_valid  out  1       1-cycle strobe, outputs updated this cycle
//  overrun           out  1       1-cycle pulse: input strobe dropped while busy
//  carrier           out  17      current signed carrier value (Q1.15, range -32768..32768)
// BEHAVIOUR
//  Reset (RST_N=0, async): outputs all 0; phase=0, step counter=0, period_q=DEFAULT_PERIOD,
//   FSM=IDLE. Reset mid-computation abandons the pair; no sample_out_valid follows.
//  Carrier timing:
//   - step counter counts 0..period_q-1; at period_q-1 it wraps to 0 and phase advances
//     (phase 31 wraps to 0).
//   - period_q reloads from max(frequency,MIN_PERIOD) only at that wrap, so a mid-step
//     change takes effect on the next step.
//   - Carrier runs continuously, including while disabled=1.
//  Carrier value, phase p, as 17-bit signed:
//   - p 0..7: p*4096; p 8..15: (16-p)*4096.
//   - p 16..23: -(p-16)*4096; p 24..31: -(32-p)*4096.
//   - p=8 is +32768 and p=24 is -32768.
//  FSM IDLE -> MUL_L -> MUL_R -> OUT -> IDLE:
//   - IDLE: on sample_in_valid, capture left_in, right_in, disabled and the carrier value
//     of that cycle, then go to MUL_L.
//   - MUL_L: left result into holding reg. MUL_R: right result into holding reg.
//   - OUT: drive left_out/right_out from the holding regs; sample_out_valid=1 for 1 cycle.
//   - Latency: strobe in cycle N gives sample_out_valid in cycle N+3.
//  Arithmetic (disabled_q=0):
//   - 33-bit signed product s*c, add 2^14, arithmetic shift right by 15.
//   - Saturate to [-32768, 32767].
//  Bypass (disabled_q=1): outputs equal the captured inputs exactly, same N+3 latency.
//  left_out/right_out hold their values between strobes.
//  sample_in_valid outside IDLE: input ignored, overrun=1 that cycle, current pair unaffected.
//  Strobe in the same cycle as OUT is also dropped with overrun; the next pair is accepted
//   from IDLE only.
// TESTING
//  1. Reset, frequency=3551, no strobes -> phase advances every 3551 CLK.
//     carrier=+32768 at step 8, -32768 at step 24.
//  2. Strobe at p=8 (c=32768), left=1000, right=-1000, disabled=0
//     -> 3 cycles later outputs 1000/-1000, valid 1 cycle.
//  3. p=24 (c=-32768), left=-32768, right=32767
//     -> left_out=32767 (saturated), right_out=-32767.
//  4. p=4 (c=16384), left=3, right=-3 -> 2 / -1 (round half up after shift).
//     Same strobe with disabled=1 -> 3 / -3.
//  5. frequency 3551->1591 mid-step -> current step still 3551 CLK, next steps 1591.
//     frequency=0 -> period 2.
//  6. Strobes 1 cycle apart -> second gives overrun pulse, only one sample_out_valid.
//     RST_N low mid-MUL_R -> outputs 0, no valid.

Source files
------------

// File: rtl/ring_modulator_core.sv
// Triangle-carrier ring modulator for a stereo pair, sharing one multiplier between L and R.
// Latency: a strobe in cycle N gives sample_out_valid in cycle N+3. No backpressure; strobes that arrive while busy are dropped and flagged on overrun.
module ring_modulator_core #(
    parameter int DATA_W         = 16,
    parameter int DEFAULT_PERIOD = 3551,
    parameter int MIN_PERIOD     = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [31:0]              frequency,
    input  logic                     disabled,
    input  logic signed [DATA_W-1:0] left_in,
    input  logic signed [DATA_W-1:0] right_in,
    input  logic                     sample_in_valid,
    output logic signed [DATA_W-1:0] left_out,
    output logic signed [DATA_W-1:0] right_out,
    output logic                     sample_out_valid,
    output logic                     overrun,
    output logic signed [16:0]       carrier
);

    localparam int PROD_W = DATA_W + 17;
    localparam logic signed [PROD_W-1:0] SAT_MAX = PROD_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] SAT_MIN = -SAT_MAX - PROD_W'(1);

    typedef enum logic [1:0] {IDLE, MUL_L, MUL_R, OUT} state_t;

    state_t                     state, state_nxt;
    logic [31:0]                step_cnt;
    logic [31:0]                period_q;
    logic [31:0]                period_nxt;
    logic [4:0]                 phase;
    logic [3:0]                 mag;
    logic signed [16:0]         mag_ext;

    logic signed [DATA_W-1:0]   left_q, right_q, hold_l;
    logic signed [16:0]         carrier_q;
    logic                       disabled_q;

    logic signed [DATA_W-1:0]   mul_a;
    logic signed [PROD_W-1:0]   prod, rounded, shifted;
    logic signed [DATA_W-1:0]   mul_res;

    assign period_nxt = (frequency < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : frequency;

    // Carrier step timing: the period reloads only at the wrap, so mid-step changes wait a step.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            step_cnt <= '0;
            period_q <= 32'(DEFAULT_PERIOD);
            phase    <= '0;
        end else if (step_cnt == period_q - 32'd1) begin
            step_cnt <= '0;
            phase    <= phase + 5'd1;
            period_q <= period_nxt;
        end else begin
            step_cnt <= step_cnt + 32'd1;
        end
    end

    // Quarter-wave magnitude in units of 4096, mirrored on phase[3], negated on phase[4].
    always_comb begin
        mag     = phase[3] ? (4'd8 - {1'b0, phase[2:0]}) : {1'b0, phase[2:0]};
        mag_ext = {1'b0, mag, 12'b0};
        carrier = phase[4] ? -mag_ext : mag_ext;
    end

    assign mul_a   = (state == MUL_L) ? left_q : right_q;
    assign prod    = $signed({{17{mul_a[DATA_W-1]}}, mul_a}) * $signed({{DATA_W{carrier_q[16]}}, carrier_q});
    assign rounded = prod + PROD_W'(16384);
    assign shifted = rounded >>> 15;

    always_comb begin
        mul_res = shifted[DATA_W-1:0];
        if (disabled_q) begin
            mul_res = mul_a;
        end else if (shifted > SAT_MAX) begin
            mul_res = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            mul_res = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            left_q     <= '0;
            right_q    <= '0;
            disabled_q <= 1'b0;
            carrier_q  <= '0;
            hold_l     <= '0;
            left_out   <= '0;
            right_out  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (sample_in_valid) begin
                        left_q     <= left_in;
                        right_q    <= right_in;
                        disabled_q <= disabled;
                        carrier_q  <= carrier;
                    end
                end
                MUL_L: hold_l <= mul_res;
                // Outputs load together on entry to OUT so both change in the valid cycle.
                MUL_R: begin
                    left_out  <= hold_l;
                    right_out <= mul_res;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt        = state;
        sample_out_valid = 1'b0;
        overrun          = 1'b0;
        case (state)
            IDLE:  if (sample_in_valid) state_nxt = MUL_L;
            MUL_L: state_nxt = MUL_R;
            MUL_R: state_nxt = OUT;
            OUT: begin
                state_nxt        = IDLE;
                sample_out_valid = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
        if (sample_in_valid && state != IDLE) overrun = 1'b1;
    end

endmodule

// File: tb/tb_ring_modulator_core.sv
// Bench for ring_modulator_core: directed vectors, step-timing sequences and random strobes against a scheduled model.
module tb_ring_modulator_core;

    localparam int DEF = 3551;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic [31:0]        frequency;
    logic               disabled;
    logic signed [15:0] left_in, right_in;
    logic               sample_in_valid;
    logic signed [15:0] left_out, right_out;
    logic               sample_out_valid;
    logic               overrun;
    logic signed [16:0] carrier;

    always #5 CLK = ~CLK;

    ring_modulator_core #(.DATA_W(16), .DEFAULT_PERIOD(DEF), .MIN_PERIOD(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .frequency(frequency), .disabled(disabled),
        .left_in(left_in), .right_in(right_in), .sample_in_valid(sample_in_valid),
        .left_out(left_out), .right_out(right_out), .sample_out_valid(sample_out_valid),
        .overrun(overrun), .carrier(carrier)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Carrier model: absolute cycle number and the cycle at which the next phase step becomes visible.
    longint cyc = 0;
    int     m_phase = 0;
    longint m_next = DEF;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cyc     <= 0;
            m_phase <= 0;
            m_next  <= DEF;
        end else begin
            cyc <= cyc + 1;
            if (cyc + 1 == m_next) begin
                m_phase <= (m_phase + 1) % 32;
                m_next  <= cyc + 1 + ((frequency < 2) ? 64'd2 : longint'(frequency));
            end
        end
    end

    typedef struct { longint c; int l; int r; } exp_t;
    exp_t   q[$];
    bit     have_acc = 0;
    longint acc_cyc = 0;
    int     hold_l = 0, hold_r = 0;

    typedef struct { int ph; int l; int r; bit dis; int ec; int el; int er; } vec_t;
    vec_t tv[6];

    function automatic int carrier_of(int p);
        if (p <= 8)       return p * 4096;
        else if (p <= 16) return (16 - p) * 4096;
        else if (p <= 24) return -(p - 16) * 4096;
        else              return -(32 - p) * 4096;
    endfunction

    function automatic int mres(int s, int c, bit dis);
        longint p;
        if (dis) return s;
        p = longint'(s) * longint'(c) + 64'sd16384;
        p = p >>> 15;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return int'(p);
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic check_cycle(input bit vld, input int l, input int r, input bit dis);
        bit busy;
        bit expv;
        int c;
        c    = carrier_of(m_phase);
        busy = have_acc && (cyc < acc_cyc + 4);
        chk("overrun", longint'(overrun), longint'(vld && busy));
        if (vld && !busy) begin
            have_acc = 1;
            acc_cyc  = cyc;
            q.push_back('{cyc + 3, mres(l, c, dis), mres(r, c, dis)});
        end
        expv = (q.size() > 0) && (q[0].c == cyc);
        chk("sample_out_valid", longint'(sample_out_valid), longint'(expv));
        if (expv) begin
            hold_l = q[0].l;
            hold_r = q[0].r;
            void'(q.pop_front());
        end
        chk("left_out", longint'(left_out), longint'(hold_l));
        chk("right_out", longint'(right_out), longint'(hold_r));
        chk("carrier", longint'(carrier), longint'(c));
    endtask

    task automatic tick(input bit vld, input int l, input int r, input bit dis);
        @(negedge CLK);
        sample_in_valid = vld;
        left_in         = 16'(l);
        right_in        = 16'(r);
        disabled        = dis;
        #1;
        check_cycle(vld, l, r, dis);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0);
    endtask

    task automatic wait_step(output int len);
        logic signed [16:0] prev;
        prev = carrier;
        len  = 0;
        do begin
            idle(1);
            len++;
        end while (carrier == prev && len < 5000);
        if (len >= 5000) chk("step_timeout", 1, 0);
    endtask

    task automatic wait_phase(input int ph);
        int n;
        n = 0;
        while (m_phase == ph && n < 4000) begin idle(1); n++; end
        while (m_phase != ph && n < 4000) begin idle(1); n++; end
        if (n >= 4000) chk("phase_timeout", 1, 0);
    endtask

    task automatic clear_sb();
        q.delete();
        have_acc = 0;
        hold_l   = 0;
        hold_r   = 0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int len, cnt, l, r;
        tv[0] = '{8,  1000,   -1000,  0,  32768,  1000,  -1000};
        tv[1] = '{24, -32768, 32767,  0, -32768,  32767, -32767};
        tv[2] = '{4,  3,      -3,     0,  16384,  2,     -1};
        tv[3] = '{4,  3,      -3,     1,  16384,  3,     -3};
        tv[4] = '{12, 20000,  -20000, 0,  16384,  10000, -10000};
        tv[5] = '{16, -1234,  4321,   1,  0,      -1234, 4321};

        RST_N = 1'b0; frequency = DEF; disabled = 0;
        left_in = 0; right_in = 0; sample_in_valid = 0;
        clear_sb();
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_left_out", longint'(left_out), 0);
        chk("rst_right_out", longint'(right_out), 0);
        chk("rst_valid", longint'(sample_out_valid), 0);
        chk("rst_overrun", longint'(overrun), 0);
        chk("rst_carrier", longint'(carrier), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        // First step runs at the reset period; the new frequency is picked up at its wrap.
        idle(100);
        frequency = 20;
        wait_step(len);
        chk("first_step_len", longint'(len + 100), DEF);
        chk("phase1_carrier", longint'(carrier), 4096);
        wait_step(len);
        chk("second_step_len", longint'(len), 20);

        for (int i = 0; i < 6; i++) begin
            wait_phase(tv[i].ph);
            tick(1, tv[i].l, tv[i].r, tv[i].dis);
            chk($sformatf("vec%0d_carrier", i), longint'(carrier), longint'(tv[i].ec));
            idle(2);
            chk($sformatf("vec%0d_early_valid", i), longint'(sample_out_valid), 0);
            idle(1);
            chk($sformatf("vec%0d_valid", i), longint'(sample_out_valid), 1);
            chk($sformatf("vec%0d_left", i), longint'(left_out), longint'(tv[i].el));
            chk($sformatf("vec%0d_right", i), longint'(right_out), longint'(tv[i].er));
            idle(1);
            chk($sformatf("vec%0d_hold_left", i), longint'(left_out), longint'(tv[i].el));
        end

        // Mid-step frequency change, then a zero frequency clamped to the minimum period.
        frequency = 3551;
        wait_step(len);
        idle(10);
        frequency = 1591;
        wait_step(len);
        chk("midchange_step_len", longint'(len + 10), 3551);
        frequency = 0;
        wait_step(len);
        chk("new_step_len", longint'(len), 1591);
        wait_step(len);
        chk("clamped_step_len", longint'(len), 2);
        frequency = 20;
        wait_step(len);

        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) frequency = $urandom_range(0, 25);
            l = ($urandom_range(0, 7) == 0) ? (($urandom_range(0, 1) == 1) ? 32767 : -32768)
                                            : int'($signed(16'($urandom)));
            r = int'($signed(16'($urandom)));
            tick($urandom_range(0, 2) == 0, l, r, $urandom_range(0, 3) == 0);
        end
        idle(4);

        tick(1, 100, 200, 0);
        tick(1, 5, 6, 0);
        chk("ovr_b2b", longint'(overrun), 1);
        cnt = 0;
        for (int i = 0; i < 5; i++) begin idle(1); cnt += int'(sample_out_valid); end
        chk("b2b_single_valid", longint'(cnt), 1);

        tick(1, 300, -300, 1);
        idle(2);
        tick(1, 7, 8, 0);
        chk("ovr_at_out", longint'(overrun), 1);
        tick(1, 9, 10, 1);
        chk("accept_after_out", longint'(overrun), 0);
        idle(3);
        chk("after_out_left", longint'(left_out), 9);
        idle(2);

        tick(1, 1000, 1000, 1);
        idle(1);
        @(negedge CLK);
        RST_N = 1'b0;
        clear_sb();
        #1;
        chk("midrst_left_out", longint'(left_out), 0);
        chk("midrst_right_out", longint'(right_out), 0);
        chk("midrst_valid", longint'(sample_out_valid), 0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin idle(1); cnt += int'(sample_out_valid); end
        chk("midrst_no_valid", longint'(cnt), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
